// File: rtl/shop_inv_v_if.sv
// Command/response bus of the shop inventory controller. The bench drives the master side.
interface shop_inv_v_if #(
  parameter int I_A_NUM_ASCII_CHARS = 7,
  parameter int O_A_NUM_ASCII_CHARS = 9,
  parameter int I_U_NUM_BITS        = 4
);
  // A command is taken on the 0->1 edge of i_rdy; i_a/i_u are sampled on that same clock edge.
  logic                               i_rdy;
  logic [I_U_NUM_BITS-1:0]            i_u;
  logic [I_A_NUM_ASCII_CHARS*8-1:0]   i_a;
  logic [O_A_NUM_ASCII_CHARS*8-1:0]   o_a;
  logic                               o_logged_in;
  logic [I_U_NUM_BITS-1:0]            o_cur_user;

  modport master (output i_rdy, i_u, i_a, input o_a, o_logged_in, o_cur_user);
  modport slave  (input i_rdy, i_u, i_a, output o_a, o_logged_in, o_cur_user);
endinterface

// File: rtl/shop_inv_v.sv
// Shop command controller: user table with admin login, item table with saturating stock,
// ASCII status held for RESP_CYCLES cycles before returning to the "Cmd?" prompt.
module shop_inv_v #(
  parameter int I_A_NUM_ASCII_CHARS = 7,
  parameter int O_A_NUM_ASCII_CHARS = 9,
  parameter int I_U_NUM_BITS        = 4,
  parameter int MAX_USERS           = 5,
  parameter int MAX_ITEMS           = 8,
  parameter int STOCK_BITS          = 4,
  parameter int RESP_CYCLES         = 4,
  parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__LOGOUT      = (I_A_NUM_ASCII_CHARS*8)'("Logout"),
  parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__LOGIN       = (I_A_NUM_ASCII_CHARS*8)'("Login"),
  parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__ADD_USER    = (I_A_NUM_ASCII_CHARS*8)'("AddUsr"),
  parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__DELETE_USER = (I_A_NUM_ASCII_CHARS*8)'("DelUsr"),
  parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__ADD_ITEM    = (I_A_NUM_ASCII_CHARS*8)'("AddItem"),
  parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__DELETE_ITEM = (I_A_NUM_ASCII_CHARS*8)'("DelItem"),
  parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__BUY         = (I_A_NUM_ASCII_CHARS*8)'("Buy")
) (
  input  logic        i_clk,
  input  logic        i_reset,
  shop_inv_v_if.slave bus,
  output logic [1:0]  dbg_state
);
  localparam int IW    = I_A_NUM_ASCII_CHARS * 8;
  localparam int OW    = O_A_NUM_ASCII_CHARS * 8;
  localparam int UW    = I_U_NUM_BITS;
  localparam int CNT_W = (RESP_CYCLES > 1) ? $clog2(RESP_CYCLES) : 1;

  localparam logic [OW-1:0] R_CMD  = OW'("Cmd?");
  localparam logic [OW-1:0] R_OK   = OW'("OK");
  localparam logic [OW-1:0] R_ICMD = OW'("InvalCmd");
  localparam logic [OW-1:0] R_PERM = OW'("InvalPerm");
  localparam logic [OW-1:0] R_ARG  = OW'("InvalArg");
  localparam logic [OW-1:0] R_EXST = OW'("Exists");
  localparam logic [OW-1:0] R_FULL = OW'("Full");
  localparam logic [OW-1:0] R_OUT  = OW'("OutStock");
  localparam logic [STOCK_BITS-1:0] STOCK_MAX = {STOCK_BITS{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  rdy_q;
  logic [IW-1:0]         cmd_q;
  logic [UW-1:0]         arg_q;
  logic [OW-1:0]         resp_q, resp_nxt;
  logic                  logged_in, logged_nxt;
  logic [UW-1:0]         cur_user, cur_nxt;
  logic [MAX_USERS-1:0]  user_valid;
  logic [STOCK_BITS-1:0] stock [MAX_ITEMS];

  logic                  accept, is_admin, user_in_rng, item_in_rng, sel_valid;
  logic [STOCK_BITS-1:0] sel_stock;
  logic                  user_set, user_clr, stock_inc, stock_dec, stock_clr;

  assign accept      = bus.i_rdy && !rdy_q;
  assign is_admin    = logged_in && (cur_user == '0);
  // Extra bit keeps the range compare correct when a table fills the whole operand space.
  assign user_in_rng = {1'b0, arg_q} < (UW+1)'(MAX_USERS);
  assign item_in_rng = {1'b0, arg_q} < (UW+1)'(MAX_ITEMS);

  always_comb begin
    sel_valid = 1'b0;
    sel_stock = '0;
    for (int i = 0; i < MAX_USERS; i++)
      if (arg_q == UW'(i)) sel_valid = user_valid[i];
    for (int i = 0; i < MAX_ITEMS; i++)
      if (arg_q == UW'(i)) sel_stock = stock[i];
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    resp_nxt   = resp_q;
    logged_nxt = logged_in;
    cur_nxt    = cur_user;
    user_set   = 1'b0;
    user_clr   = 1'b0;
    stock_inc  = 1'b0;
    stock_dec  = 1'b0;
    stock_clr  = 1'b0;
    case (state)
      IDLE: begin
        resp_nxt = R_CMD;
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = RESP;
        cnt_nxt   = CNT_W'(RESP_CYCLES - 1);
        if (cmd_q == CMD_KEY__LOGIN) begin
          if (logged_in)                       resp_nxt = R_PERM;
          else if (!user_in_rng || !sel_valid) resp_nxt = R_ARG;
          else begin
            logged_nxt = 1'b1;
            cur_nxt    = arg_q;
            resp_nxt   = R_OK;
          end
        end else if (cmd_q == CMD_KEY__LOGOUT) begin
          if (!logged_in) resp_nxt = R_PERM;
          else begin
            logged_nxt = 1'b0;
            cur_nxt    = '0;
            resp_nxt   = R_OK;
          end
        end else if (cmd_q == CMD_KEY__ADD_USER) begin
          if (!is_admin)                          resp_nxt = R_PERM;
          else if (arg_q == '0 || !user_in_rng)   resp_nxt = R_ARG;
          else if (sel_valid)                     resp_nxt = R_EXST;
          else begin user_set = 1'b1; resp_nxt = R_OK; end
        end else if (cmd_q == CMD_KEY__DELETE_USER) begin
          if (!is_admin)                                      resp_nxt = R_PERM;
          else if (arg_q == '0 || !user_in_rng || !sel_valid) resp_nxt = R_ARG;
          else begin user_clr = 1'b1; resp_nxt = R_OK; end
        end else if (cmd_q == CMD_KEY__ADD_ITEM) begin
          if (!is_admin)                  resp_nxt = R_PERM;
          else if (!item_in_rng)          resp_nxt = R_ARG;
          else if (sel_stock == STOCK_MAX) resp_nxt = R_FULL;
          else begin stock_inc = 1'b1; resp_nxt = R_OK; end
        end else if (cmd_q == CMD_KEY__DELETE_ITEM) begin
          if (!is_admin)              resp_nxt = R_PERM;
          else if (!item_in_rng)      resp_nxt = R_ARG;
          else if (sel_stock == '0)   resp_nxt = R_ARG;
          else begin stock_clr = 1'b1; resp_nxt = R_OK; end
        end else if (cmd_q == CMD_KEY__BUY) begin
          if (!logged_in)             resp_nxt = R_PERM;
          else if (!item_in_rng)      resp_nxt = R_ARG;
          else if (sel_stock == '0)   resp_nxt = R_OUT;
          else begin stock_dec = 1'b1; resp_nxt = R_OK; end
        end else begin
          resp_nxt = R_ICMD;
        end
      end
      RESP: begin
        // A new strobe cuts the current response short; o_a holds it through EXEC.
        if (accept)           state_nxt = EXEC;
        else if (cnt == '0) begin
          state_nxt = IDLE;
          resp_nxt  = R_CMD;
        end else              cnt_nxt = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rdy_q      <= 1'b1;
      cmd_q      <= '0;
      arg_q      <= '0;
      resp_q     <= R_CMD;
      logged_in  <= 1'b0;
      cur_user   <= '0;
      user_valid <= MAX_USERS'(1);
      for (int i = 0; i < MAX_ITEMS; i++) stock[i] <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rdy_q     <= bus.i_rdy;
      resp_q    <= resp_nxt;
      logged_in <= logged_nxt;
      cur_user  <= cur_nxt;
      if (accept) begin
        cmd_q <= bus.i_a;
        arg_q <= bus.i_u;
      end
      for (int i = 0; i < MAX_USERS; i++)
        if (arg_q == UW'(i)) begin
          if (user_set) user_valid[i] <= 1'b1;
          if (user_clr) user_valid[i] <= 1'b0;
        end
      for (int i = 0; i < MAX_ITEMS; i++)
        if (arg_q == UW'(i)) begin
          if (stock_inc) stock[i] <= stock[i] + 1'b1;
          if (stock_dec) stock[i] <= stock[i] - 1'b1;
          if (stock_clr) stock[i] <= '0;
        end
    end
  end

  assign bus.o_a         = resp_q;
  assign bus.o_logged_in = logged_in;
  assign bus.o_cur_user  = cur_user;
  assign dbg_state       = state;
endmodule

// File: tb/tb_shop_inv_v.sv
// Directed bench for shop_inv_v: command sequences with hand-computed responses,
// response timing, truncation by a second strobe, and reset in the middle of a response.
module tb_shop_inv_v;
  localparam int RESP_CYCLES = 4;
  localparam int IW = 56;
  localparam int OW = 72;

  localparam logic [OW-1:0] R_CMD  = OW'("Cmd?");
  localparam logic [OW-1:0] R_OK   = OW'("OK");
  localparam logic [OW-1:0] R_ICMD = OW'("InvalCmd");
  localparam logic [OW-1:0] R_PERM = OW'("InvalPerm");
  localparam logic [OW-1:0] R_ARG  = OW'("InvalArg");
  localparam logic [OW-1:0] R_EXST = OW'("Exists");
  localparam logic [OW-1:0] R_FULL = OW'("Full");
  localparam logic [OW-1:0] R_OUT  = OW'("OutStock");

  localparam logic [IW-1:0] C_LOGIN  = IW'("Login");
  localparam logic [IW-1:0] C_LOGOUT = IW'("Logout");
  localparam logic [IW-1:0] C_ADDU   = IW'("AddUsr");
  localparam logic [IW-1:0] C_DELU   = IW'("DelUsr");
  localparam logic [IW-1:0] C_ADDI   = IW'("AddItem");
  localparam logic [IW-1:0] C_DELI   = IW'("DelItem");
  localparam logic [IW-1:0] C_BUY    = IW'("Buy");
  localparam logic [IW-1:0] C_JUNK   = IW'("sdfsdf");

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;

  shop_inv_v_if #(.I_A_NUM_ASCII_CHARS(7), .O_A_NUM_ASCII_CHARS(9), .I_U_NUM_BITS(4)) bus ();

  shop_inv_v #(.RESP_CYCLES(RESP_CYCLES)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got '%s' (%h) expected '%s' (%h)", tag, got, got, exp, exp);
    end
  endtask

  // Raise i_rdy for one edge; returns on the negedge right after the accepting edge.
  task automatic strobe(input logic [IW-1:0] a, input logic [3:0] u);
    @(negedge clk);
    bus.i_a   = a;
    bus.i_u   = u;
    bus.i_rdy = 1'b1;
    @(negedge clk);
    bus.i_rdy = 1'b0;
  endtask

  task automatic cmd(input string tag, input logic [IW-1:0] a, input logic [3:0] u,
                     input logic [OW-1:0] exp);
    strobe(a, u);
    tick(1);
    check(tag, bus.o_a, exp);
    tick(RESP_CYCLES);
  endtask

  initial begin
    bus.i_rdy = 1'b0;
    bus.i_u   = '0;
    bus.i_a   = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("reset_o_a", bus.o_a, R_CMD);
    check("reset_logged_in", OW'(bus.o_logged_in), OW'(0));
    check("reset_cur_user", OW'(bus.o_cur_user), OW'(0));
    check("reset_state", OW'(dbg_state), OW'(0));

    // Unknown command: held for RESP_CYCLES cycles, then the prompt.
    strobe(C_JUNK, 4'd0);
    check("junk_exec_prompt", bus.o_a, R_CMD);
    for (int i = 0; i < RESP_CYCLES; i++) begin
      tick(1);
      check($sformatf("junk_hold%0d", i), bus.o_a, R_ICMD);
    end
    tick(1);
    check("junk_back_prompt", bus.o_a, R_CMD);
    check("junk_no_login", OW'(bus.o_logged_in), OW'(0));

    cmd("additem_loggedout", C_ADDI, 4'd2, R_PERM);
    cmd("login_admin", C_LOGIN, 4'd0, R_OK);
    check("admin_logged_in", OW'(bus.o_logged_in), OW'(1));
    check("admin_cur_user", OW'(bus.o_cur_user), OW'(0));

    for (int i = 0; i < 15; i++) cmd($sformatf("additem3_%0d", i), C_ADDI, 4'd3, R_OK);
    cmd("additem3_full", C_ADDI, 4'd3, R_FULL);
    cmd("additem8_range", C_ADDI, 4'd8, R_ARG);

    cmd("addusr2", C_ADDU, 4'd2, R_OK);
    cmd("addusr2_again", C_ADDU, 4'd2, R_EXST);
    cmd("logout_admin", C_LOGOUT, 4'd0, R_OK);
    check("logout_flag", OW'(bus.o_logged_in), OW'(0));
    cmd("login_u2", C_LOGIN, 4'd2, R_OK);
    check("u2_cur_user", OW'(bus.o_cur_user), OW'(2));
    cmd("buy3_u2", C_BUY, 4'd3, R_OK);
    cmd("delitem3_u2", C_DELI, 4'd3, R_PERM);
    cmd("buy5_empty", C_BUY, 4'd5, R_OUT);
    cmd("login_twice", C_LOGIN, 4'd0, R_PERM);
    cmd("addusr_nonadmin", C_ADDU, 4'd3, R_PERM);
    // Stock 3 is now 14: exactly fourteen more buys succeed.
    for (int i = 0; i < 14; i++) cmd($sformatf("buy3_%0d", i), C_BUY, 4'd3, R_OK);
    cmd("buy3_drained", C_BUY, 4'd3, R_OUT);
    cmd("buy8_range", C_BUY, 4'd8, R_ARG);
    cmd("logout_u2", C_LOGOUT, 4'd0, R_OK);
    cmd("logout_twice", C_LOGOUT, 4'd0, R_PERM);
    cmd("buy_loggedout", C_BUY, 4'd3, R_PERM);

    cmd("login_admin2", C_LOGIN, 4'd0, R_OK);
    cmd("additem4", C_ADDI, 4'd4, R_OK);
    cmd("delitem4", C_DELI, 4'd4, R_OK);
    cmd("delitem4_empty", C_DELI, 4'd4, R_ARG);
    cmd("buy4_after_del", C_BUY, 4'd4, R_OUT);
    cmd("delitem3_empty", C_DELI, 4'd3, R_ARG);
    cmd("delusr2", C_DELU, 4'd2, R_OK);
    cmd("delusr2_again", C_DELU, 4'd2, R_ARG);
    cmd("delusr0", C_DELU, 4'd0, R_ARG);
    cmd("addusr5_range", C_ADDU, 4'd5, R_ARG);
    cmd("addusr0", C_ADDU, 4'd0, R_ARG);
    cmd("addusr4_top", C_ADDU, 4'd4, R_OK);
    cmd("logout_admin2", C_LOGOUT, 4'd0, R_OK);
    cmd("login_deleted_u2", C_LOGIN, 4'd2, R_ARG);
    cmd("login_u5_range", C_LOGIN, 4'd5, R_ARG);
    cmd("login_u4", C_LOGIN, 4'd4, R_OK);
    check("u4_cur_user", OW'(bus.o_cur_user), OW'(4));
    cmd("logout_u4", C_LOGOUT, 4'd0, R_OK);
    cmd("login_admin3", C_LOGIN, 4'd0, R_OK);

    // Second strobe two cycles into a response restarts the hold counter.
    strobe(C_ADDI, 4'd6);
    tick(1);
    check("trunc_first", bus.o_a, R_OK);
    tick(1);
    strobe(C_BUY, 4'd9);
    check("trunc_exec_hold", bus.o_a, R_OK);
    check("trunc_exec_state", OW'(dbg_state), OW'(1));
    tick(1);
    check("trunc_second", bus.o_a, R_ARG);
    tick(1);
    check("trunc_restart", bus.o_a, R_ARG);
    tick(RESP_CYCLES - 2);
    check("trunc_last_hold", bus.o_a, R_ARG);
    tick(1);
    check("trunc_prompt", bus.o_a, R_CMD);

    // Reset during a response, with i_rdy rising on the reset edge and held high after it.
    strobe(C_ADDI, 4'd6);
    tick(1);
    check("prereset_resp", bus.o_a, R_OK);
    rst       = 1'b1;
    bus.i_a   = C_LOGOUT;
    bus.i_rdy = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("midreset_o_a", bus.o_a, R_CMD);
    check("midreset_logged_in", OW'(bus.o_logged_in), OW'(0));
    tick(3);
    check("rdy_high_ignored", bus.o_a, R_CMD);
    check("rdy_high_state", OW'(dbg_state), OW'(0));
    bus.i_rdy = 1'b0;
    cmd("postreset_login", C_LOGIN, 4'd0, R_OK);
    cmd("postreset_buy6", C_BUY, 4'd6, R_OUT);
    cmd("postreset_addusr4", C_ADDU, 4'd4, R_OK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shop_inv_v.md
Name: shop_inv_v

Overview:
- Parametrised successor to the single-user shop command controller.
- Accepts ASCII commands on i_a, strobed by rising edges of i_rdy, with a numeric operand on i_u (user id or item id).
- Maintains a user table of MAX_USERS entries with an admin login, plus a MAX_ITEMS item table with saturating stock counters.
- Returns an ASCII status on o_a for RESP_CYCLES cycles, then returns to the "Cmd?" prompt.

Parameters:
- I_A_NUM_ASCII_CHARS, 7, command width in chars; must fit the longest CMD_KEY.
- O_A_NUM_ASCII_CHARS, 9, response width in chars; must fit "InvalPerm".
- I_U_NUM_BITS, 4, operand width; 2**I_U_NUM_BITS >= max(MAX_USERS, MAX_ITEMS).
- MAX_USERS, 5, user slots including admin (id 0).
- MAX_ITEMS, 8, item slots.
- STOCK_BITS, 4, stock counter width; maximum stock is 2**STOCK_BITS-1.
- RESP_CYCLES, 4, cycles a response is held before "Cmd?"; must be >= 1.
- CMD_KEY__LOGOUT/LOGIN/ADD_USER/DELETE_USER/ADD_ITEM/DELETE_ITEM/BUY, "Logout"/"Login"/"AddUsr"/"DelUsr"/"AddItem"/"DelItem"/"Buy", command strings.

Ports:
- i_clk, in, 1, clock; all logic on rising edge.
- i_reset, in, 1, synchronous active-high reset.
- i_rdy, in, 1, command strobe; a command is accepted on its 0->1 transition.
- i_u, in, I_U_NUM_BITS, unsigned operand.
- i_a, in, I_A_NUM_ASCII_CHARS*8, ASCII command, right-justified, zero-padded on the left.
- o_a, out, O_A_NUM_ASCII_CHARS*8, ASCII response, right-justified, zero-padded.
- o_logged_in, out, 1, a user session is active.
- o_cur_user, out, I_U_NUM_BITS, id of the logged-in user; 0 when logged out.

Behaviour:
- Reset (synchronous, high on an edge):
  - o_a = "Cmd?", o_logged_in = 0, o_cur_user = 0.
  - User valid bits: only user 0 valid. All stock = 0.
  - State = IDLE. rdy_q = 1, so i_rdy must be seen low before the first accept.
  - Reset wins over a simultaneous i_rdy edge (command discarded). Reset mid-RESP aborts the response.
- Edge detect: rdy_q <= i_rdy every cycle. Accept when i_rdy=1 and rdy_q=0; i_a and i_u are registered on that edge.
- States and latency:
  - IDLE: o_a = "Cmd?"; on accept -> EXEC.
  - EXEC: one cycle; decode and update tables; load the response; -> RESP with counter = RESP_CYCLES-1.
  - RESP: o_a holds the response; counter decrements; at 0 -> IDLE.
  - An accept during RESP -> EXEC immediately; the current response is truncated.
  - An accept cannot occur in EXEC, since i_rdy must go low between accepts.
  - Latency: accept on edge N; tables and o_a update on edge N+1; o_a returns to "Cmd?" on edge N+1+RESP_CYCLES absent new commands.
- Command decode: full-width equality of i_a against the keys. No match -> "InvalCmd" with no state change.
- Permission and argument checks, in this order:
  1. Login: already logged in -> "InvalPerm"; i_u >= MAX_USERS or user invalid -> "InvalArg"; else logged_in = 1, cur_user = i_u, "OK".
  2. Logout: not logged in -> "InvalPerm"; else logged_in = 0, cur_user = 0, "OK".
  3. AddUsr and DelUsr: require logged_in and cur_user == 0, else "InvalPerm".
     - AddUsr: i_u == 0 or i_u >= MAX_USERS -> "InvalArg"; already valid -> "Exists"; else set valid, "OK".
     - DelUsr: i_u == 0, i_u >= MAX_USERS, or user invalid -> "InvalArg"; else clear valid, "OK".
  4. AddItem and DelItem: admin only, else "InvalPerm"; i_u >= MAX_ITEMS -> "InvalArg".
     - AddItem: stock at max -> "Full" with stock unchanged; else stock + 1, "OK".
     - DelItem: stock == 0 -> "InvalArg"; else stock = 0, "OK".
  5. Buy: requires logged_in (any user, including admin), else "InvalPerm"; i_u >= MAX_ITEMS -> "InvalArg"; stock == 0 -> "OutStock"; else stock - 1, "OK".
- Arithmetic: stock is unsigned STOCK_BITS wide, with no wrap in either direction.
- o_logged_in and o_cur_user update in the EXEC cycle, together with o_a.

Test Plan:
- Reset, then i_a="sdfsdf" strobe -> o_a="InvalCmd" for 4 cycles, then "Cmd?"; no state change.
- Logged out, i_a="AddItem" i_u=2 -> "InvalPerm"; then i_a="Login" i_u=0 -> "OK", o_logged_in=1, o_cur_user=0.
- As admin, AddItem i_u=3 sixteen times -> 15 x "OK" then "Full"; stock[3] = 15. AddItem i_u=8 -> "InvalArg".
- As admin: AddUsr i_u=2 -> "OK"; AddUsr i_u=2 -> "Exists"; Logout -> "OK"; Login i_u=2 -> "OK"; Buy i_u=3 -> "OK", stock 14; DelItem i_u=3 -> "InvalPerm".
- Buy i_u=5 with stock 0 -> "OutStock"; Login while logged in -> "InvalPerm".
- Second strobe 2 cycles into RESP -> new response on the next edge and counter restarted; reset asserted mid-RESP -> "Cmd?", logged out, stock cleared, i_rdy held high at reset release not accepted.
